// File: rtl/plru_replacer.sv
// Multi-set tree-PLRU replacement engine: per-set tree state, hit/fill touches,
// and a one-cycle-latency victim query with invalid-first and lock-mask handling.
module plru_replacer #(
  parameter int WAY_COUNT       = 8,
  parameter int SET_COUNT       = 16,
  parameter bit TOUCH_ON_VICTIM = 1'b1,
  localparam int SET_W          = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush_i,
  input  logic                 access_valid_i,
  input  logic [SET_W-1:0]     access_set_i,
  input  logic [WAY_COUNT-1:0] access_way_i,
  input  logic                 victim_req_i,
  input  logic [SET_W-1:0]     victim_set_i,
  input  logic [WAY_COUNT-1:0] way_valid_i,
  input  logic [WAY_COUNT-1:0] way_lock_i,
  output logic                 victim_valid_o,
  output logic [WAY_COUNT-1:0] victim_way_o,
  output logic                 victim_none_o
);

  localparam int NODES = WAY_COUNT - 1;
  localparam int LVL   = $clog2(WAY_COUNT);

  logic [NODES-1:0] tree_q [SET_COUNT];
  logic [NODES-1:0] tree_d [SET_COUNT];

  function automatic logic [LVL-1:0] oh_to_idx(input logic [WAY_COUNT-1:0] oh);
    logic [LVL-1:0] idx;
    idx = '0;
    for (int i = 0; i < WAY_COUNT; i++)
      if (oh[i]) idx = idx | LVL'(i);
    return idx;
  endfunction

  // Every node on the path to way w is pointed at the sibling subtree.
  function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t,
                                             input logic [LVL-1:0]   w);
    int node;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      t[node] = ~w[LVL-1-l];
      node    = 2 * node + (w[LVL-1-l] ? 2 : 1);
    end
    return t;
  endfunction

  function automatic logic [LVL-1:0] walk(input logic [NODES-1:0]     t,
                                          input logic [WAY_COUNT-1:0] elig);
    int node;
    int lo;
    int half;
    logic go_r;
    logic [WAY_COUNT-1:0] mask;
    logic [WAY_COUNT-1:0] lset;
    logic [WAY_COUNT-1:0] rset;
    node = 0;
    lo   = 0;
    for (int l = 0; l < LVL; l++) begin
      half = WAY_COUNT >> (l + 1);
      mask = {WAY_COUNT{1'b1}} >> (WAY_COUNT - half);
      lset = (elig >> lo) & mask;
      rset = (elig >> (lo + half)) & mask;
      go_r = t[node];
      if (go_r && (rset == '0))
        go_r = 1'b0;
      else if (!go_r && (lset == '0))
        go_r = 1'b1;
      if (go_r) lo = lo + half;
      node = 2 * node + (go_r ? 2 : 1);
    end
    return lo[LVL-1:0];
  endfunction

  logic                 acc_set_ok;
  logic                 vic_set_ok;
  logic                 acc_ok;
  logic                 vic_none;
  logic                 vic_touch;
  logic [SET_W-1:0]     vic_set_eff;
  logic [LVL-1:0]       acc_idx;
  logic [LVL-1:0]       vic_idx;
  logic [NODES-1:0]     vic_tree;
  logic [WAY_COUNT-1:0] eligible;
  logic [WAY_COUNT-1:0] inv_elig;
  logic [WAY_COUNT-1:0] vic_way;

  // Stage p0: victim selection on the access-bypassed tree of the queried set
  always_comb begin
    acc_set_ok  = (int'(access_set_i) < SET_COUNT);
    vic_set_ok  = (int'(victim_set_i) < SET_COUNT);
    acc_ok      = access_valid_i && $onehot(access_way_i) && acc_set_ok;
    vic_set_eff = vic_set_ok ? victim_set_i : '0;
    acc_idx     = oh_to_idx(access_way_i);
    vic_tree    = tree_q[vic_set_eff];
    if (acc_ok && (access_set_i == vic_set_eff))
      vic_tree = touch(vic_tree, acc_idx);
    eligible = ~way_lock_i;
    inv_elig = eligible & ~way_valid_i;
    vic_none = (eligible == '0);
    if (vic_none)
      vic_idx = '0;
    else if (inv_elig != '0)
      vic_idx = oh_to_idx(inv_elig & (-inv_elig));
    else
      vic_idx = walk(vic_tree, eligible);
    vic_way   = vic_none ? '0 : ({{(WAY_COUNT-1){1'b0}}, 1'b1} << vic_idx);
    vic_touch = TOUCH_ON_VICTIM && victim_req_i && !vic_none && vic_set_ok;
  end

  // Access touch first, then victim touch, so a same-set victim ends MRU.
  always_comb begin
    for (int s = 0; s < SET_COUNT; s++) begin
      tree_d[s] = tree_q[s];
      if (acc_ok && (int'(access_set_i) == s))
        tree_d[s] = touch(tree_d[s], acc_idx);
      if (vic_touch && (int'(victim_set_i) == s))
        tree_d[s] = touch(tree_d[s], vic_idx);
      if (flush_i)
        tree_d[s] = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SET_COUNT; s++)
        tree_q[s] <= '0;
    end else begin
      for (int s = 0; s < SET_COUNT; s++)
        tree_q[s] <= tree_d[s];
    end
  end

  // Stage p1: registered victim result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      victim_valid_o <= 1'b0;
      victim_way_o   <= '0;
      victim_none_o  <= 1'b0;
    end else begin
      victim_valid_o <= victim_req_i;
      if (victim_req_i) begin
        victim_way_o  <= vic_way;
        victim_none_o <= vic_none;
      end
    end
  end

  always @(posedge clk) begin
    if (rstn) begin
      if (access_valid_i) assert ($onehot(access_way_i));
      if (access_valid_i) assert (acc_set_ok);
      if (victim_req_i)   assert (vic_set_ok);
    end
  end

endmodule
